// File: rtl/projectile_controller.sv
// Enemy projectile pool for level 1: spawns below the enemy on a frame cadence,
// moves slots down once per frame, retires them at the screen bottom or on player contact.
module projectile_controller #(
  parameter int SPAWN_PERIOD = 60,
  parameter int PROJ_SPEED   = 3,
  parameter int PROJ_W       = 5,
  parameter int PROJ_H       = 12,
  parameter int SPRITE_SIZE  = 16,
  parameter int SCREEN_H     = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [2:0] game_state,
  input  logic [1:0] level,
  input  logic [9:0] enemy_x,
  input  logic [9:0] enemy_y,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] proj0_x,
  output logic [9:0] proj0_y,
  output logic       proj0_active,
  output logic [9:0] proj1_x,
  output logic [9:0] proj1_y,
  output logic       proj1_active,
  output logic [9:0] proj2_x,
  output logic [9:0] proj2_y,
  output logic       proj2_active,
  output logic [9:0] proj3_x,
  output logic [9:0] proj3_y,
  output logic       proj3_active,
  output logic       player_hit
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  logic [9:0]       x_reg [4];
  logic [9:0]       y_reg [4];
  logic             active_reg [4];
  logic [CNT_W-1:0] cnt_reg;
  logic             hit_reg;

  logic [10:0] y_new [4];
  logic [3:0]  active_vec;
  logic [3:0]  retire;
  logic [3:0]  hit_slot;
  logic [3:0]  free_vec;
  logic [3:0]  spawn_sel;
  logic [10:0] spawn_y;
  logic [9:0]  spawn_x;
  logic        wrap;
  logic        spawn_ok;
  logic        update;

  assign update = frame_tick && (level == 2'd1) && (game_state == 3'd0);

  // All geometry is done in 11 bits so sums near the screen edge cannot wrap.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_slot
      assign active_vec[gi] = active_reg[gi];
      assign y_new[gi]      = {1'b0, y_reg[gi]} + 11'(PROJ_SPEED);
      assign retire[gi]     = active_reg[gi] && (y_new[gi] >= 11'(SCREEN_H));
      assign hit_slot[gi]   = active_reg[gi] && !retire[gi]
                           && ({1'b0, x_reg[gi]} < ({1'b0, player_x} + 11'(SPRITE_SIZE)))
                           && ({1'b0, player_x}  < ({1'b0, x_reg[gi]} + 11'(PROJ_W)))
                           && (y_new[gi]          < ({1'b0, player_y} + 11'(SPRITE_SIZE)))
                           && ({1'b0, player_y}  < (y_new[gi] + 11'(PROJ_H)));
    end
  endgenerate

  // Only slots empty before the tick may receive a spawn; lowest index wins.
  assign free_vec  = ~active_vec;
  assign spawn_sel = free_vec & (~free_vec + 4'd1);
  assign wrap      = (cnt_reg == CNT_W'(SPAWN_PERIOD - 1));
  assign spawn_y   = {1'b0, enemy_y} + 11'(SPRITE_SIZE);
  assign spawn_x   = enemy_x + 10'((SPRITE_SIZE - PROJ_W) / 2);
  assign spawn_ok  = wrap && (spawn_y < 11'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        x_reg[i]      <= '0;
        y_reg[i]      <= '0;
        active_reg[i] <= 1'b0;
      end
    end else if (level != 2'd1) begin
      for (int i = 0; i < 4; i++) active_reg[i] <= 1'b0;
    end else if (update) begin
      for (int i = 0; i < 4; i++) begin
        if (spawn_ok && spawn_sel[i]) begin
          x_reg[i]      <= spawn_x;
          y_reg[i]      <= spawn_y[9:0];
          active_reg[i] <= 1'b1;
        end else if (active_reg[i]) begin
          if (retire[i]) begin
            active_reg[i] <= 1'b0;
          end else begin
            y_reg[i] <= y_new[i][9:0];
            if (hit_slot[i]) active_reg[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (level != 2'd1)) begin
      cnt_reg <= '0;
    end else if (update) begin
      cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hit_reg <= 1'b0;
    else     hit_reg <= update && (|hit_slot);
  end

  assign proj0_x      = x_reg[0];
  assign proj0_y      = y_reg[0];
  assign proj0_active = active_reg[0];
  assign proj1_x      = x_reg[1];
  assign proj1_y      = y_reg[1];
  assign proj1_active = active_reg[1];
  assign proj2_x      = x_reg[2];
  assign proj2_y      = y_reg[2];
  assign proj2_active = active_reg[2];
  assign proj3_x      = x_reg[3];
  assign proj3_y      = y_reg[3];
  assign proj3_active = active_reg[3];
  assign player_hit   = hit_reg;

endmodule

// File: tb/tb_projectile_controller.sv
// Bench for projectile_controller: directed table, hand sequences and randomized
// traffic, all checked against an arithmetic reference model of the projectile rules.
module tb_projectile_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] game_state = 3'd0;
  logic [1:0] level = 2'd1;
  logic [9:0] enemy_x = 10'd300, enemy_y = 10'd100, player_x = 10'd0, player_y = 10'd0;

  logic [9:0] ox [2][4];
  logic [9:0] oy [2][4];
  logic       oa [2][4];
  logic       oh [2];

  int n_tests = 0;
  int n_fail  = 0;
  int n_hits  = 0;

  always #5 clk = ~clk;

  projectile_controller #(.SPAWN_PERIOD(60)) dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_state(game_state), .level(level),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .player_x(player_x), .player_y(player_y),
    .proj0_x(ox[0][0]), .proj0_y(oy[0][0]), .proj0_active(oa[0][0]),
    .proj1_x(ox[0][1]), .proj1_y(oy[0][1]), .proj1_active(oa[0][1]),
    .proj2_x(ox[0][2]), .proj2_y(oy[0][2]), .proj2_active(oa[0][2]),
    .proj3_x(ox[0][3]), .proj3_y(oy[0][3]), .proj3_active(oa[0][3]),
    .player_hit(oh[0])
  );

  projectile_controller #(.SPAWN_PERIOD(2)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_state(game_state), .level(level),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .player_x(player_x), .player_y(player_y),
    .proj0_x(ox[1][0]), .proj0_y(oy[1][0]), .proj0_active(oa[1][0]),
    .proj1_x(ox[1][1]), .proj1_y(oy[1][1]), .proj1_active(oa[1][1]),
    .proj2_x(ox[1][2]), .proj2_y(oy[1][2]), .proj2_active(oa[1][2]),
    .proj3_x(ox[1][3]), .proj3_y(oy[1][3]), .proj3_active(oa[1][3]),
    .player_hit(oh[1])
  );

  // Reference model: a pool of four slots and a count of updates since the last spawn attempt.
  int mx [2][4];
  int my [2][4];
  bit ma [2][4];
  int mcnt [2];
  bit mhit [2];
  int period [2] = '{60, 2};

  function automatic void model_edge(int k);
    int free_slot;
    bit any_hit;
    int ny, px, py;
    mhit[k] = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin ma[k][i] = 0; mx[k][i] = 0; my[k][i] = 0; end
      mcnt[k] = 0;
      return;
    end
    if (level != 2'd1) begin
      for (int i = 0; i < 4; i++) ma[k][i] = 0;
      mcnt[k] = 0;
      return;
    end
    if (game_state != 3'd0 || !frame_tick) return;
    free_slot = -1;
    for (int i = 3; i >= 0; i--) if (!ma[k][i]) free_slot = i;
    px = int'(player_x);
    py = int'(player_y);
    any_hit = 0;
    for (int i = 0; i < 4; i++) begin
      if (ma[k][i]) begin
        ny = my[k][i] + 3;
        if (ny >= 480) ma[k][i] = 0;
        else begin
          my[k][i] = ny;
          if (mx[k][i] < px + 16 && px < mx[k][i] + 5 && ny < py + 16 && py < ny + 12) begin
            ma[k][i] = 0;
            any_hit = 1;
          end
        end
      end
    end
    mhit[k] = any_hit;
    mcnt[k] = (mcnt[k] + 1) % period[k];
    if (mcnt[k] == 0 && free_slot >= 0 && int'(enemy_y) + 16 < 480) begin
      ma[k][free_slot] = 1;
      mx[k][free_slot] = int'(enemy_x) + 5;
      my[k][free_slot] = int'(enemy_y) + 16;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic [84:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      got = '0;
      exp = '0;
      for (int i = 0; i < 4; i++) begin
        got[i] = oa[k][i];
        exp[i] = ma[k][i];
        got[4 + 10*i +: 10]  = ox[k][i];
        exp[4 + 10*i +: 10]  = 10'(mx[k][i]);
        got[44 + 10*i +: 10] = oy[k][i];
        exp[44 + 10*i +: 10] = 10'(my[k][i]);
      end
      got[84] = oh[k];
      exp[84] = mhit[k];
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL model dut%0d @%0t: got %h expected %h", k, $time, got, exp);
      end
    end
  endtask

  task automatic cyc(input bit ft);
    frame_tick = ft;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    model_check();
    if (oh[0]) n_hits++;
  endtask

  function automatic int mask_of(int k);
    return {28'd0, oa[k][3], oa[k][2], oa[k][1], oa[k][0]};
  endfunction

  typedef struct {
    bit         do_rst;
    int         ticks;
    logic [2:0] gs;
    logic [1:0] lvl;
    int         ex, ey, plx, ply;
    int         mask, x0, y0;
    bit         hit;
  } vec_t;

  vec_t vecs [19];

  initial begin
    //            rst ticks gs lvl  ex   ey  plx  ply  mask  x0   y0  hit
    vecs[0]  = '{1, 0,   0, 1, 300, 100,   0,   0, 4'b0000,   0,   0, 0};
    vecs[1]  = '{0, 60,  0, 1, 300, 100,   0,   0, 4'b0001, 305, 116, 0};
    vecs[2]  = '{0, 1,   0, 1, 300, 100,   0,   0, 4'b0001, 305, 119, 0};
    vecs[3]  = '{0, 119, 0, 1, 300, 100,   0,   0, 4'b0111, 305, 476, 0};
    vecs[4]  = '{0, 1,   0, 1, 300, 100,   0,   0, 4'b0111, 305, 479, 0};
    vecs[5]  = '{0, 1,   0, 1, 300, 100,   0,   0, 4'b0110, 305, 479, 0};
    vecs[6]  = '{1, 0,   0, 1, 300, 100,   0,   0, 4'b0000,   0,   0, 0};
    vecs[7]  = '{0, 60,  0, 1, 300, 100,   0,   0, 4'b0001, 305, 116, 0};
    vecs[8]  = '{0, 59,  0, 1, 300, 100,   0,   0, 4'b0001, 305, 293, 0};
    vecs[9]  = '{0, 1,   0, 1, 300, 280,   0,   0, 4'b0011, 305, 296, 0};
    vecs[10] = '{0, 1,   0, 1, 300, 280, 300, 290, 4'b0000, 305, 299, 1};
    vecs[11] = '{1, 0,   0, 1, 300, 100,   0,   0, 4'b0000,   0,   0, 0};
    vecs[12] = '{0, 60,  0, 1, 300, 100,   0,   0, 4'b0001, 305, 116, 0};
    vecs[13] = '{0, 20,  1, 1, 300, 100,   0,   0, 4'b0001, 305, 116, 0};
    vecs[14] = '{0, 1,   0, 1, 300, 100,   0,   0, 4'b0001, 305, 119, 0};
    vecs[15] = '{0, 1,   0, 0, 300, 100,   0,   0, 4'b0000, 305, 119, 0};
    vecs[16] = '{0, 59,  0, 1, 300, 100,   0,   0, 4'b0000, 305, 119, 0};
    vecs[17] = '{0, 1,   0, 1, 300, 100,   0,   0, 4'b0001, 305, 116, 0};
    vecs[18] = '{1, 1,   0, 1, 300, 100, 300, 130, 4'b0000,   0,   0, 0};

    for (int v = 0; v < 19; v++) begin
      game_state = vecs[v].gs;
      level      = vecs[v].lvl;
      enemy_x    = 10'(vecs[v].ex);
      enemy_y    = 10'(vecs[v].ey);
      player_x   = 10'(vecs[v].plx);
      player_y   = 10'(vecs[v].ply);
      if (vecs[v].do_rst) begin
        rst = 1'b1;
        cyc(vecs[v].ticks > 0);
        rst = 1'b0;
      end else begin
        for (int t = 0; t < vecs[v].ticks; t++) begin
          if (t > 0) cyc(1'b0);
          cyc(1'b1);
        end
      end
      chk($sformatf("vec%0d mask", v), mask_of(0), vecs[v].mask);
      chk($sformatf("vec%0d x0", v), int'(ox[0][0]), vecs[v].x0);
      chk($sformatf("vec%0d y0", v), int'(oy[0][0]), vecs[v].y0);
      chk($sformatf("vec%0d hit", v), int'(oh[0]), int'(vecs[v].hit));
    end

    // Single hit: pulse lasts exactly one cycle.
    game_state = 3'd0; level = 2'd1; enemy_x = 10'd300; enemy_y = 10'd100;
    player_x = 10'd0; player_y = 10'd0;
    rst = 1'b1; cyc(1'b0); rst = 1'b0;
    for (int t = 0; t < 60; t++) begin cyc(1'b1); cyc(1'b0); end
    player_x = 10'd300; player_y = 10'd130;
    cyc(1'b1);
    chk("single hit active", int'(oa[0][0]), 0);
    chk("single hit pulse", int'(oh[0]), 1);
    cyc(1'b0);
    chk("hit pulse end", int'(oh[0]), 0);
    cyc(1'b0);
    chk("hit pulse stays low", int'(oh[0]), 0);

    // Short-period instance: slots fill on ticks 2,4,6,8; tick 10 finds no free slot.
    player_x = 10'd0; player_y = 10'd400; enemy_y = 10'd0;
    rst = 1'b1; cyc(1'b0); rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      cyc(1'b1);
      chk($sformatf("fill tick%0d mask", t), mask_of(1), (1 << ((t / 2 > 4) ? 4 : t / 2)) - 1);
    end
    chk("fill slot3 x", int'(ox[1][3]), 305);
    chk("fill slot3 y", int'(oy[1][3]), 16 + 3 * 2);

    // Spawn y at the screen bottom is dropped; one pixel higher spawns and then retires.
    rst = 1'b1; cyc(1'b0); rst = 1'b0;
    enemy_y = 10'd464;
    cyc(1'b1); cyc(1'b1);
    chk("spawn y=480 dropped", mask_of(1), 0);
    enemy_y = 10'd463;
    cyc(1'b1); cyc(1'b1);
    chk("spawn y=479 mask", mask_of(1), 1);
    chk("spawn y=479 y0", int'(oy[1][0]), 479);
    cyc(1'b1);
    chk("retire at bottom", mask_of(1), 0);
    chk("retire holds y", int'(oy[1][0]), 479);

    // Randomized traffic against the model.
    enemy_x = 10'd300; enemy_y = 10'd100;
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      game_state = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      level = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      if (c % 64 == 0) begin
        enemy_x = 10'($urandom_range(280, 330));
        enemy_y = 10'($urandom_range(0, 479));
      end
      if (c % 8 == 0) begin
        player_x = 10'($urandom_range(270, 345));
        player_y = 10'($urandom_range(0, 479));
      end
      cyc(1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    chk("random traffic produced hits", int'(n_hits > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
